// File: rtl/add_arbiter_seq.sv
// Round-robin arbiter/sequencer sharing one 16-bit adder between two requesters.
// Narrow ops take one adder beat, wide ops two beats chained through a registered carry.
module add_arbiter_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_sub,
  input  logic        req0_wide,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_sub,
  input  logic        req1_wide,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  output logic        add_cin,
  input  logic [15:0] add_s,
  input  logic        add_cout,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_sum,
  output logic        rsp_cout,
  output logic        rsp_ovf
);
  typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

  state_t      state_q, state_d;
  logic        ptr_q;
  logic [31:0] a_q, b_q, sum_q;
  logic        sub_q, wide_q, id_q, carry_q, cout_q, ovf_q;
  logic        gnt0, gnt1, accept;
  logic [31:0] sel_a, sel_b;
  logic        sel_sub, sel_wide, beat_ovf;

  // Pointer names the requester that wins a tie.
  assign gnt0   = req0_valid & (~req1_valid | ~ptr_q);
  assign gnt1   = req1_valid & (~req0_valid |  ptr_q);
  assign accept = (state_q == IDLE) & (gnt0 | gnt1);

  assign req0_ready = (state_q == IDLE) & gnt0;
  assign req1_ready = (state_q == IDLE) & gnt1;

  assign sel_a    = gnt1 ? req1_a    : req0_a;
  assign sel_b    = gnt1 ? req1_b    : req0_b;
  assign sel_sub  = gnt1 ? req1_sub  : req0_sub;
  assign sel_wide = gnt1 ? req1_wide : req0_wide;

  always_comb begin
    state_d = state_q;
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    case (state_q)
      IDLE: if (accept) state_d = LO;
      LO: begin
        add_a   = a_q[15:0];
        add_b   = b_q[15:0];
        add_cin = sub_q;
        state_d = wide_q ? HI : RESP;
      end
      HI: begin
        add_a   = a_q[31:16];
        add_b   = b_q[31:16];
        add_cin = carry_q;
        state_d = RESP;
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // add_a/add_b hold the current beat's operand halves, so their MSBs are the sign bits.
  assign beat_ovf = (add_a[15] == add_b[15]) & (add_s[15] != add_a[15]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      sub_q   <= 1'b0;
      wide_q  <= 1'b0;
      id_q    <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (accept) begin
        ptr_q  <= gnt0;
        id_q   <= gnt1;
        a_q    <= sel_a;
        b_q    <= sel_sub ? ~sel_b : sel_b;
        sub_q  <= sel_sub;
        wide_q <= sel_wide;
        sum_q  <= '0;
      end
      if (state_q == LO) begin
        sum_q[15:0] <= add_s;
        carry_q     <= add_cout;
        cout_q      <= add_cout;
        ovf_q       <= beat_ovf;
      end
      if (state_q == HI) begin
        sum_q[31:16] <= add_s;
        carry_q      <= add_cout;
        cout_q       <= add_cout;
        ovf_q        <= beat_ovf;
      end
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = rsp_valid & id_q;
  assign rsp_sum   = rsp_valid ? sum_q : '0;
  assign rsp_cout  = rsp_valid & cout_q;
  assign rsp_ovf   = rsp_valid & ovf_q;
endmodule

// File: tb/tb_add_arbiter_seq.sv
// Randomized and directed bench for add_arbiter_seq against an arithmetic reference model.
module tb_add_arbiter_seq;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        wide;
  } op_t;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic        req0_sub = 0, req0_wide = 0, req1_sub = 0, req1_wide = 0;
  logic [15:0] add_a, add_b, add_s;
  logic        add_cin, add_cout;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_cout, rsp_ovf;
  logic [31:0] rsp_sum;

  add_arbiter_seq dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_sub(req0_sub), .req0_wide(req0_wide),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_sub(req1_sub), .req1_wide(req1_wide),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_s(add_s), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf)
  );

  always #5 clk = ~clk;

  // The shared adder itself.
  always_comb {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};

  int errs = 0, checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic at the operation width.
  function automatic void ref_op(input op_t o, output logic [31:0] s, output logic c, output logic v);
    longint m, ua, ub, sa, sb, r, u;
    m  = o.wide ? (longint'(1) << 32) : (longint'(1) << 16);
    ua = o.wide ? longint'(o.a) : longint'(o.a[15:0]);
    ub = o.wide ? longint'(o.b) : longint'(o.b[15:0]);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    r  = o.sub ? sa - sb : sa + sb;
    u  = o.sub ? ua - ub : ua + ub;
    c  = o.sub ? (ua >= ub) : (u >= m);
    s  = 32'(((u % m) + m) % m);
    v  = (r >= m / 2) || (r < -(m / 2));
  endfunction

  op_t         q0[$], q1[$];
  int          grants[$];
  logic [34:0] rsp_log[$];
  bit          m_busy = 0, m_ptr = 0, m_id = 0, acc0 = 0, acc1 = 0, saw_hi = 0, gaps = 0;
  bit          lo_cout = 0, hi_cin = 0;
  int          m_wait = 0, rr_mode = 0;
  op_t         m_op;

  task automatic observe();
    bit v0, v1, e0, e1, hi;
    op_t c0, c1;
    logic [31:0] es, be;
    logic ec, eo;
    logic [16:0] lo;
    @(negedge clk);
    v0 = req0_valid; v1 = req1_valid;
    c0 = {req0_a, req0_b, req0_sub, req0_wide};
    c1 = {req1_a, req1_b, req1_sub, req1_wide};
    acc0 = req0_valid & req0_ready;
    acc1 = req1_valid & req1_ready;
    saw_hi = 0;
    chk("ready_excl", {63'd0, req0_ready & req1_ready}, 0);
    if (!m_busy) begin
      e0 = v0 && (!v1 || !m_ptr);
      e1 = v1 && (!v0 || m_ptr);
      chk("ready0", req0_ready, e0);
      chk("ready1", req1_ready, e1);
      chk("rsp_valid_idle", rsp_valid, 0);
      chk("adder_idle", {add_a, add_b, add_cin}, 0);
      if (e0 || e1) begin
        m_id = e1; m_op = e1 ? c1 : c0; m_ptr = !e1;
        m_busy = 1; m_wait = m_op.wide ? 2 : 1;
        grants.push_back(int'(e1));
      end
    end else if (m_wait > 0) begin
      chk("ready_busy", {req0_ready, req1_ready}, 0);
      chk("rsp_valid_busy", rsp_valid, 0);
      be = m_op.sub ? ~m_op.b : m_op.b;
      lo = {1'b0, m_op.a[15:0]} + {1'b0, be[15:0]} + {16'd0, m_op.sub};
      hi = m_op.wide && (m_wait == 1);
      if (!hi) begin
        chk("lo_beat", {add_a, add_b, add_cin}, {m_op.a[15:0], be[15:0], m_op.sub});
        lo_cout = add_cout;
      end else begin
        chk("hi_beat", {add_a, add_b, add_cin}, {m_op.a[31:16], be[31:16], lo[16]});
        hi_cin = add_cin;
        saw_hi = 1;
      end
      m_wait--;
    end else begin
      ref_op(m_op, es, ec, eo);
      chk("ready_resp", {req0_ready, req1_ready}, 0);
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_fields", {rsp_id, rsp_cout, rsp_ovf, rsp_sum}, {m_id, ec, eo, es});
      chk("adder_resp", {add_a, add_b, add_cin}, 0);
      if (rsp_ready) begin
        m_busy = 0;
        rsp_log.push_back({rsp_id, rsp_cout, rsp_ovf, rsp_sum});
      end
    end
  endtask

  task automatic drive();
    op_t o;
    @(posedge clk); #1;
    if (acc0 || !req0_valid) begin
      if (q0.size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
        o = q0.pop_front();
        {req0_a, req0_b, req0_sub, req0_wide} = o;
        req0_valid = 1;
      end else req0_valid = 0;
    end
    if (acc1 || !req1_valid) begin
      if (q1.size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
        o = q1.pop_front();
        {req1_a, req1_b, req1_sub, req1_wide} = o;
        req1_valid = 1;
      end else req1_valid = 0;
    end
    acc0 = 0; acc1 = 0;
    rsp_ready = (rr_mode == 0) ? 1'b1 : (rr_mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
  endtask

  task automatic cycle();
    observe();
    drive();
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || req0_valid || req1_valid || m_busy) && n < maxc) begin
      cycle();
      n++;
    end
    if (n >= maxc) chk("timeout", 1, 0);
  endtask

  function automatic logic [31:0] rv();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_7FFF;
      default: return $urandom();
    endcase
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.a = rv(); o.b = rv();
    o.sub = 1'($urandom_range(0, 1)); o.wide = 1'($urandom_range(0, 1));
    return o;
  endfunction

  function automatic op_t mk(input logic [31:0] a, input logic [31:0] b, input logic sub, input logic wide);
    op_t o;
    o.a = a; o.b = b; o.sub = sub; o.wide = wide;
    return o;
  endfunction

  initial begin
    int n;
    #3;
    chk("rst_ctl", {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_cout, rsp_ovf, add_cin}, 0);
    chk("rst_data", {rsp_sum, add_a, add_b}, 0);
    @(negedge clk); rst_n = 1;

    // Contended requesters from reset: strict alternation starting with req0.
    for (int i = 0; i < 3; i++) begin q0.push_back(rand_op()); q1.push_back(rand_op()); end
    grants.delete();
    drain(100);
    chk("fair_count", grants.size(), 6);
    for (int i = 0; i < 6 && i < grants.size(); i++) chk("fair_order", grants[i], i % 2);

    // Directed arithmetic cases.
    rsp_log.delete();
    q0.push_back(mk(32'h0000_1234, 32'h0000_0FFF, 0, 0));
    drain(50);
    q1.push_back(mk(32'h0000_FFFF, 32'h0000_0001, 0, 1));
    drain(50);
    chk("chain_lo_cout", lo_cout, 1);
    chk("chain_hi_cin", hi_cin, 1);
    q0.push_back(mk(32'd5, 32'd7, 1, 0));
    q0.push_back(mk(32'h0000_7FFF, 32'h0000_0001, 0, 0));
    q0.push_back(mk(32'h8000_0000, 32'h0000_0001, 1, 1));
    drain(100);
    chk("dir_count", rsp_log.size(), 5);
    if (rsp_log.size() == 5) begin
      chk("narrow_add", rsp_log[0], {1'b0, 1'b0, 1'b0, 32'h0000_2233});
      chk("wide_chain", rsp_log[1], {1'b1, 1'b0, 1'b0, 32'h0001_0000});
      chk("narrow_sub", rsp_log[2], {1'b0, 1'b0, 1'b0, 32'h0000_FFFE});
      chk("narrow_ovf", rsp_log[3], {1'b0, 1'b0, 1'b1, 32'h0000_8000});
      chk("wide_subovf", rsp_log[4], {1'b0, 1'b1, 1'b1, 32'h7FFF_FFFF});
    end

    // Backpressure: hold RESP five cycles while another request waits.
    q0.push_back(rand_op()); q1.push_back(rand_op());
    rr_mode = 2;
    n = 0;
    while (!(m_busy && m_wait == 0) && n < 20) begin cycle(); n++; end
    if (n >= 20) chk("bp_timeout", 1, 0);
    repeat (5) cycle();
    rr_mode = 0;
    drain(50);

    // Randomized traffic with gaps and random backpressure.
    gaps = 1; rr_mode = 1;
    for (int i = 0; i < 800; i++) begin
      if (q0.size() < 2 && $urandom_range(0, 3) == 0) q0.push_back(rand_op());
      if (q1.size() < 2 && $urandom_range(0, 3) == 0) q1.push_back(rand_op());
      cycle();
    end
    drain(200);
    gaps = 0; rr_mode = 0;

    // Reset during the high beat of a req0 wide op (pointer is then 1).
    q0.push_back(mk(32'h1234_FFFF, 32'h0000_0001, 0, 1));
    n = 0;
    saw_hi = 0;
    while (n < 20) begin
      observe();
      if (saw_hi) break;
      drive();
      n++;
    end
    if (n >= 20) chk("hi_timeout", 1, 0);
    #2 rst_n = 0;
    #1;
    chk("midrst_ctl", {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_cout, rsp_ovf, add_cin}, 0);
    chk("midrst_data", {rsp_sum, add_a, add_b}, 0);
    m_busy = 0; m_ptr = 0; acc0 = 0; acc1 = 0;
    @(posedge clk); #1;
    chk("midrst_hold", {rsp_valid, add_a, add_b, rsp_sum}, 0);
    @(negedge clk); rst_n = 1;
    q0.push_back(rand_op()); q1.push_back(rand_op());
    grants.delete();
    drain(50);
    chk("rst_ptr_count", grants.size(), 2);
    if (grants.size() > 0) chk("rst_ptr_first", grants[0], 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected done");
    $fatal(1);
  end
endmodule
